// File: rtl/logic_stage_16bit.sv
// Registered OR/AND/XOR/ANDN stage with zero flag and a 2-entry skid buffer (in_ready from a flop).
// Optional macro LOGIC_STAGE_PARITY_EN adds out_par, an even-parity bit stored alongside each result.
module logic_stage_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
`ifdef LOGIC_STAGE_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] or_bits, and_bits, xor_bits, andn_bits, result;
  logic [WIDTH-1:0] main_res, skid_res;
  logic             main_zero, skid_zero;
  logic             accept;
  logic             load_main_new, load_main_skid, load_skid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign or_bits[i]   = in1[i] | in2[i];
    assign and_bits[i]  = in1[i] & in2[i];
    assign xor_bits[i]  = in1[i] ^ in2[i];
    assign andn_bits[i] = in1[i] & ~in2[i];
  end

  always_comb begin
    case (op)
      2'b00:   result = or_bits;
      2'b01:   result = and_bits;
      2'b10:   result = xor_bits;
      default: result = andn_bits;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign out       = main_res;
  assign out_zero  = main_zero;

  always_comb begin
    next_state     = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state    = ONE;
          load_main_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          load_main_new = 1'b1;
        end else if (accept) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (out_ready) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          next_state     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // in_ready stays low for the reset cycle and only then tracks "skid not full"
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_res  <= '0;
      main_zero <= 1'b0;
      skid_res  <= '0;
      skid_zero <= 1'b0;
    end else begin
      if (load_main_new) begin
        main_res  <= result;
        main_zero <= ~|result;
      end else if (load_main_skid) begin
        main_res  <= skid_res;
        main_zero <= skid_zero;
      end
      if (load_skid) begin
        skid_res  <= result;
        skid_zero <= ~|result;
      end
    end
  end

`ifdef LOGIC_STAGE_PARITY_EN
  logic skid_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_par  <= 1'b0;
      skid_par <= 1'b0;
    end else begin
      if (load_main_new) begin
        out_par <= ^result;
      end else if (load_main_skid) begin
        out_par <= skid_par;
      end
      if (load_skid) begin
        skid_par <= ^result;
      end
    end
  end
`endif

endmodule

// File: tb/tb_logic_stage_16bit.sv
// Self-checking bench for logic_stage_16bit: directed scenarios plus random traffic
// compared against a queue-based FIFO reference model (honours LOGIC_STAGE_PARITY_EN).
module tb_logic_stage_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        out_zero;
`ifdef LOGIC_STAGE_PARITY_EN
  logic        out_par;
`endif

  logic_stage_16bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero)
`ifdef LOGIC_STAGE_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: ordered queue of pending results plus the expected in_ready level
  logic [15:0] exp_q[$];
  bit          m_ready = 1'b0;
  bit          m_known = 1'b0;

  function automatic logic [15:0] refResult(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b);
    case (o)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compareModel();
    if (!m_known) return;
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      checkOutput("out", {16'b0, out}, {16'b0, exp_q[0]});
      checkOutput("out_zero", {31'b0, out_zero}, {31'b0, exp_q[0] == 16'h0000});
`ifdef LOGIC_STAGE_PARITY_EN
      checkOutput("out_par", {31'b0, out_par}, {31'b0, ^exp_q[0]});
`endif
    end
  endtask

  // One cycle: check the model at the falling edge, then drive inputs for the next rising edge
  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] o,
                               input logic [15:0] a, input logic [15:0] b, input bit ordy);
    bit acc;
    bit drn;
    @(negedge clk);
    compareModel();
    rst       = r;
    in_valid  = v;
    op        = o;
    in1       = a;
    in2       = b;
    out_ready = ordy;
    if (r) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_known = 1'b1;
    end else begin
      acc = v && m_ready;
      drn = (exp_q.size() != 0) && ordy;
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(refResult(o, a, b));
      m_ready = (exp_q.size() < 2);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; in1 = '0; in2 = '0; out_ready = 1'b0;

    // Reset held two cycles with in_valid high
    applyStimulus(1, 1, 2'b00, 16'h1234, 16'h0001, 0);
    applyStimulus(1, 1, 2'b00, 16'h1234, 16'h0001, 0);
    checkOutput("rst_out", {16'b0, out}, 32'h0);
    checkOutput("rst_zero", {31'b0, out_zero}, 32'h0);
    applyStimulus(0, 1, 2'b00, 16'h1234, 16'h0001, 0);
    checkOutput("rst_in_ready_low", {31'b0, in_ready}, 32'h0);
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
    checkOutput("rst_in_ready_high", {31'b0, in_ready}, 32'h1);

    // Op coverage
    applyStimulus(0, 1, 2'b00, 16'hF0F0, 16'h0FF0, 1);
    applyStimulus(0, 1, 2'b01, 16'hF0F0, 16'h0FF0, 1);
    checkOutput("op_or", {16'b0, out}, 32'hFFF0);
    applyStimulus(0, 1, 2'b10, 16'hF0F0, 16'h0FF0, 1);
    checkOutput("op_and", {16'b0, out}, 32'h00F0);
    applyStimulus(0, 1, 2'b11, 16'hF0F0, 16'h0FF0, 1);
    checkOutput("op_xor", {16'b0, out}, 32'hFF00);
    applyStimulus(0, 1, 2'b01, 16'hAAAA, 16'h5555, 1);
    checkOutput("op_andn", {16'b0, out}, 32'hF000);
    checkOutput("op_andn_zero", {31'b0, out_zero}, 32'h0);

    // Zero flag (and parity)
    applyStimulus(0, 1, 2'b00, 16'h0001, 16'h0000, 1);
    checkOutput("zero_out", {16'b0, out}, 32'h0);
    checkOutput("zero_flag", {31'b0, out_zero}, 32'h1);
`ifdef LOGIC_STAGE_PARITY_EN
    checkOutput("par_zero", {31'b0, out_par}, 32'h0);
`endif
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
`ifdef LOGIC_STAGE_PARITY_EN
    checkOutput("par_one", {31'b0, out_par}, 32'h1);
`endif
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);

    // Backpressure: three words, downstream stalled
    applyStimulus(0, 1, 2'b00, 16'h0001, 16'h0000, 0);
    applyStimulus(0, 1, 2'b00, 16'h0002, 16'h0000, 0);
    applyStimulus(0, 1, 2'b00, 16'h0004, 16'h0000, 0);
    checkOutput("bp_in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("bp_head", {16'b0, out}, 32'h0001);
    applyStimulus(0, 1, 2'b00, 16'h0004, 16'h0000, 0);
    checkOutput("bp_hold", {16'b0, out}, 32'h0001);
    applyStimulus(0, 1, 2'b00, 16'h0004, 16'h0000, 1);
    applyStimulus(0, 1, 2'b00, 16'h0004, 16'h0000, 1);
    checkOutput("bp_second", {16'b0, out}, 32'h0002);
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
    checkOutput("bp_third", {16'b0, out}, 32'h0004);
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
    checkOutput("bp_drained", {31'b0, out_valid}, 32'h0);

    // Full throughput
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1);
    end
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);

    // Reset mid-flight from FULL
    applyStimulus(0, 1, 2'b00, 16'h00AA, 16'h0000, 0);
    applyStimulus(0, 1, 2'b00, 16'h00BB, 16'h0000, 0);
    applyStimulus(1, 1, 2'b00, 16'h00CC, 16'h0000, 0);
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
    checkOutput("midrst_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("midrst_out", {16'b0, out}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                    $urandom_range(0, 3) != 0);
    end
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);
    applyStimulus(0, 0, 2'b00, 16'h0000, 16'h0000, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
